// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side controller for an 8-deep synchronous byte FIFO.
// It issues read requests (fifo_rn) and captures each word one cycle after its request.
// Words are re-presented in order on a valid/ready stream through a 2-entry skid buffer.
// Optional feature macro: FIFO_READER_COUNT_EN adds the rd_count delivered-word counter.
// When the macro is defined, the CNT_W parameter is added as well.
module fifo_stream_reader #(
    parameter int DATA_W = 8
`ifdef FIFO_READER_COUNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              fifo_empty,
    input  logic              fifo_wr_busy,
    output logic              fifo_rn,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
`ifdef FIFO_READER_COUNT_EN
    , output logic [CNT_W-1:0] rd_count
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e              occ_q, occ_d;
    logic              inflight_q, inflight_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic              pop;
    logic [1:0]        level;

    // Read issue: this cycle's pop frees a slot, so it is subtracted before the space test
    always_comb begin
        pop     = out_valid_q & out_ready;
        level   = 2'(occ_q) + {1'b0, inflight_q} - {1'b0, pop};
        fifo_rn = reset_n & ~fifo_empty & ~fifo_wr_busy & (level < 2'd2);
    end

    // Next-state for the skid buffer: capture the in-flight word at the tail, pop from the head
    always_comb begin
        occ_d      = occ_q;
        head_d     = head_q;
        tail_d     = tail_q;
        inflight_d = fifo_rn;
        case ({inflight_q, pop})
            2'b10: begin
                if (occ_q == EMPTY) begin
                    head_d = fifo_dout;
                    occ_d  = ONE;
                end else begin
                    tail_d = fifo_dout;
                    occ_d  = TWO;
                end
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = (occ_q == TWO) ? ONE : EMPTY;
            end
            2'b11: begin
                // Occupancy is unchanged; with two entries the tail shifts up before the new word lands
                if (occ_q == TWO) begin
                    head_d = tail_q;
                    tail_d = fifo_dout;
                end else begin
                    head_d = fifo_dout;
                end
            end
            default: ;
        endcase
        out_valid_d = (occ_d != EMPTY);
    end

    // Buffer state registers; reset discards held and in-flight words
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            occ_q       <= EMPTY;
            inflight_q  <= 1'b0;
            out_valid_q <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
        end else begin
            occ_q       <= occ_d;
            inflight_q  <= inflight_d;
            out_valid_q <= out_valid_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = head_q;

`ifdef FIFO_READER_COUNT_EN
    logic [CNT_W-1:0] rd_count_q, rd_count_d;

    // Delivered-word count, wrapping naturally at 2^CNT_W
    always_comb begin
        rd_count_d = rd_count_q + CNT_W'(pop);
    end

    // Counter register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
        end
    end

    assign rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader. It contains a behavioural FIFO model whose data
// appears one cycle after a read request. Words written to the model are queued as expected
// stream output, and a monitor checks every transfer against that queue.
module tb_fifo_stream_reader;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       fifo_empty;
    logic       fifo_wr_busy;
    logic       fifo_rn;
    logic [7:0] fifo_dout = 8'h00;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
`ifdef FIFO_READER_COUNT_EN
    logic [3:0] rd_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0]  fmem [0:255];
    int unsigned wp = 0;
    int unsigned rp = 0;
    logic [7:0]  expq [$];

    fifo_stream_reader #(
        .DATA_W(8)
`ifdef FIFO_READER_COUNT_EN
        , .CNT_W(4)
`endif
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .fifo_empty  (fifo_empty),
        .fifo_wr_busy(fifo_wr_busy),
        .fifo_rn     (fifo_rn),
        .fifo_dout   (fifo_dout),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready)
`ifdef FIFO_READER_COUNT_EN
        , .rd_count  (rd_count)
`endif
    );

    always #5 clock = ~clock;

    // FIFO model: a reset flushes the contents; an accepted read presents its data after the edge
    assign fifo_empty = (wp == rp);
    always @(posedge clock) begin
        if (!reset_n) begin
            rp <= wp;
        end else if (fifo_rn) begin
            fifo_dout <= fmem[rp[7:0]];
            rp        <= rp + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fmem[wp[7:0]] = b;
        wp = wp + 1;
        expq.push_back(b);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clock);
            if (expq.size() == 0 && !out_valid) done = 1'b1;
        end
        chk(name, {31'd0, done}, 32'd1);
    endtask

    // Monitor: every stream transfer must match the oldest outstanding expected word
    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=%0h expected=none", out_data);
            end else begin
                chk("sb_data", {24'd0, out_data}, {24'd0, expq.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit         rn_exp [6];
        bit         v_exp  [6];
        logic [7:0] d_exp  [6];
        int         pulses;

        rn_exp = '{1, 1, 1, 0, 0, 0};
        v_exp  = '{0, 0, 1, 1, 1, 0};
        d_exp  = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};

        // Reset state, with a non-empty FIFO and a ready consumer
        reset_n      = 1'b0;
        out_ready    = 1'b1;
        fifo_wr_busy = 1'b0;
        fmem[0]      = 8'h99;
        wp           = 1;
        #2;
        chk("reset_rn", {31'd0, fifo_rn}, 32'd0);
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_data", {24'd0, out_data}, 32'h00);
        step();
        step();
        reset_n = 1'b1;

        // Three words with the consumer always ready: latency and throughput
        step();
        push(8'h11);
        push(8'h22);
        push(8'h33);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("lat_rn", {31'd0, fifo_rn}, {31'd0, rn_exp[i]});
            chk("lat_valid", {31'd0, out_valid}, {31'd0, v_exp[i]});
            if (v_exp[i]) chk("lat_data", {24'd0, out_data}, {24'd0, d_exp[i]});
        end

        // Stalled consumer: only two reads are issued and the head word is held
        step();
        out_ready = 1'b0;
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        push(8'hA4);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (fifo_rn) pulses++;
            if (i >= 2) chk("hold_data", {24'd0, out_data}, 32'hA1);
        end
        chk("stall_rn_pulses", pulses, 2);
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("burst_valid", {31'd0, out_valid}, 32'd1);
        end
        wait_drain("drain_stall");

        // Writer priority: fifo_wr_busy holds off reads without losing or repeating any word
        step();
        fifo_wr_busy = 1'b1;
        push(8'hE0);
        push(8'hE1);
        push(8'hE2);
        push(8'hE3);
        push(8'hE4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("busy_rn", {31'd0, fifo_rn}, 32'd0);
        end
        step();
        fifo_wr_busy = 1'b0;
        @(negedge clock);
        chk("resume_rn", {31'd0, fifo_rn}, 32'd1);
        wait_drain("drain_busy");

        // Reset while the buffer is full: valid drops at once and old contents are discarded
        step();
        out_ready = 1'b0;
        push(8'hF1);
        push(8'hF2);
        push(8'hF3);
        push(8'hF4);
        for (int i = 0; i < 4; i++) @(negedge clock);
        chk("full_valid", {31'd0, out_valid}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rn", {31'd0, fifo_rn}, 32'd0);
        expq.delete();
        step();
        step();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        push(8'h5A);
        wait_drain("drain_after_reset");

        // Seventeen words in a row; with the counter build a 4-bit count wraps to 1
        step();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 17; i++) push(8'h60 + 8'(i));
        wait_drain("drain_17");
`ifdef FIFO_READER_COUNT_EN
        chk("rd_count_wrap", {28'd0, rd_count}, 32'h1);
`endif
        chk("idle_valid", {31'd0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
